// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl
// Byte-level I2C master. Turns a parallel command (7-bit address, R/W,
// write byte) into START / address / data / ACK / STOP sequences on
// open-drain SDA and SCL, paced by the phase outputs of the I2C clock divider.
//
// Ports
//   clk           system clock (shared with the divider)
//   reset         synchronous, active-low
//   scl_clk       divider SCL phase
//   data_clk      divider data phase
//   data_clk_prev data_clk delayed by one clk
//   ena           transaction request / continue (level)
//   addr, rw      slave address and direction (1 = read)
//   data_wr       byte to write
//   sda_in        synchronised SDA pin level
//   busy          command accepted / transfer in progress
//   data_rd       last byte read
//   ack_error     slave NACK seen since last START
//   sda_oe        1 = pull SDA low
//   scl_oe        1 = pull SCL low
module i2c_master_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_clk,
    input  logic       data_clk,
    input  logic       data_clk_prev,
    input  logic       ena,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       sda_in,
    output logic       busy,
    output logic [7:0] data_rd,
    output logic       ack_error,
    output logic       sda_oe,
    output logic       scl_oe
);

    typedef enum logic [3:0] {
        READY,
        START,
        COMMAND,
        SLV_ACK1,
        WR,
        RD,
        SLV_ACK2,
        MSTR_ACK,
        STOP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       scl_ena;
    logic       sda_int;
    logic [2:0] bit_cnt;
    logic [7:0] addr_rw;
    logic [7:0] data_tx;
    logic [7:0] data_rx;

    // rise: SCL low, bits change; fall: SCL high, bits are sampled.
    logic       rise;
    logic       fall;
    logic [7:0] cmd;
    logic       same_cmd;

    assign rise     = data_clk & ~data_clk_prev;
    assign fall     = ~data_clk & data_clk_prev;
    assign cmd      = {addr, rw};
    assign same_cmd = (cmd == addr_rw);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: transitions only on rise
    always_comb begin
        state_nxt = state;
        if (rise) begin
            case (state)
                READY:    if (ena) state_nxt = START;
                START:    state_nxt = COMMAND;
                COMMAND:  if (bit_cnt == 3'd0) state_nxt = SLV_ACK1;
                SLV_ACK1: state_nxt = addr_rw[0] ? RD : WR;
                WR:       if (bit_cnt == 3'd0) state_nxt = SLV_ACK2;
                RD:       if (bit_cnt == 3'd0) state_nxt = MSTR_ACK;
                SLV_ACK2: begin
                    if (!ena)          state_nxt = STOP;
                    else if (same_cmd) state_nxt = WR;
                    else               state_nxt = START;
                end
                MSTR_ACK: begin
                    if (!ena)          state_nxt = STOP;
                    else if (same_cmd) state_nxt = RD;
                    else               state_nxt = START;
                end
                STOP:     state_nxt = READY;
                default:  state_nxt = READY;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            scl_ena   <= 1'b0;
            sda_int   <= 1'b1;
            bit_cnt   <= 3'd7;
            addr_rw   <= '0;
            data_tx   <= '0;
            data_rx   <= '0;
            data_rd   <= '0;
            ack_error <= 1'b0;
        end else if (rise) begin
            case (state)
                READY: begin
                    busy    <= ena;
                    sda_int <= 1'b1;
                    if (ena) begin
                        addr_rw <= cmd;
                        data_tx <= data_wr;
                    end
                end
                START: begin
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    sda_int   <= addr_rw[7];
                    bit_cnt   <= 3'd7;
                end
                COMMAND: begin
                    if (bit_cnt == 3'd0) begin
                        sda_int <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        sda_int <= addr_rw[bit_cnt - 3'd1];
                    end
                end
                SLV_ACK1: begin
                    bit_cnt <= 3'd7;
                    sda_int <= addr_rw[0] ? 1'b1 : data_tx[7];
                end
                WR: begin
                    busy <= 1'b1;
                    if (bit_cnt == 3'd0) begin
                        sda_int <= 1'b1;
                        bit_cnt <= 3'd7;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        sda_int <= data_tx[bit_cnt - 3'd1];
                    end
                end
                RD: begin
                    busy <= 1'b1;
                    if (bit_cnt == 3'd0) begin
                        // ACK only when the user is continuing the same read
                        sda_int <= ~(ena & same_cmd);
                        bit_cnt <= 3'd7;
                        data_rd <= data_rx;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                end
                SLV_ACK2: begin
                    if (ena) begin
                        busy    <= 1'b0;
                        addr_rw <= cmd;
                        data_tx <= data_wr;
                        if (same_cmd) sda_int <= data_wr[7];
                    end
                end
                MSTR_ACK: begin
                    if (ena) begin
                        busy    <= 1'b0;
                        addr_rw <= cmd;
                        data_tx <= data_wr;
                        if (same_cmd) sda_int <= 1'b1;
                    end
                end
                STOP: begin
                    busy    <= 1'b0;
                    sda_int <= 1'b1;
                end
                default: ;
            endcase
        end else if (fall) begin
            case (state)
                START:              scl_ena   <= 1'b1;
                STOP:               scl_ena   <= 1'b0;
                SLV_ACK1, SLV_ACK2: ack_error <= ack_error | sda_in;
                RD:                 data_rx[bit_cnt] <= sda_in;
                default: ;
            endcase
        end
    end

    // Line drivers. START pulls SDA only in phase 3 (SCL high) and STOP
    // releases it only in phase 3, producing the bus conditions.
    always_comb begin
        scl_oe = scl_ena & ~scl_clk;
        case (state)
            START:   sda_oe = scl_clk & ~data_clk;
            STOP:    sda_oe = ~(scl_clk & ~data_clk);
            default: sda_oe = ~sda_int;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl
// Directed bench for i2c_master_ctrl: divider model, bus monitor that
// decodes START/STOP/bytes/ACKs, and a simple slave that ACKs and returns
// read data.
module tb_i2c_master_ctrl;

    localparam int EV_ACK   = 256;
    localparam int EV_START = 512;
    localparam int EV_STOP  = 513;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data_wr;
    logic       sda_in;
    logic       busy;
    logic [7:0] data_rd;
    logic       ack_error;
    logic       sda_oe;
    logic       scl_oe;

    // Divider model: 4 clk per phase, 16 clk per SCL period
    logic [3:0] div_cnt = 4'd0;
    logic       data_clk_prev = 1'b0;
    logic       scl_clk;
    logic       data_clk;
    assign scl_clk  = div_cnt[3];
    assign data_clk = (div_cnt[3:2] == 2'd1) || (div_cnt[3:2] == 2'd2);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div_cnt       <= div_cnt + 4'd1;
        data_clk_prev <= data_clk;
    end

    logic       slv_pull = 1'b0;
    logic       ack_en = 1'b1;
    logic [7:0] rd_byte = 8'h00;
    assign sda_in = ~(sda_oe | slv_pull);

    i2c_master_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .scl_clk       (scl_clk),
        .data_clk      (data_clk),
        .data_clk_prev (data_clk_prev),
        .ena           (ena),
        .addr          (addr),
        .rw            (rw),
        .data_wr       (data_wr),
        .sda_in        (sda_in),
        .busy          (busy),
        .data_rd       (data_rd),
        .ack_error     (ack_error),
        .sda_oe        (sda_oe),
        .scl_oe        (scl_oe)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor / slave, sampled on negedge
    int         mlog[$];
    int         exp_q[$];
    logic       m_scl_p = 1'b1;
    logic       m_sda_p = 1'b1;
    logic       m_pend = 1'b0;
    int         m_bitn = 0;
    int         m_frame = 0;
    logic [7:0] m_sh = 8'h00;
    logic       m_rd = 1'b0;
    logic       m_nacked = 1'b0;

    initial begin : monitor
        logic scl_l;
        logic sda_l;
        forever begin
            @(negedge clk);
            scl_l = ~scl_oe;
            sda_l = sda_in;
            if (m_scl_p && scl_l) begin
                if (m_sda_p && !sda_l) m_pend = 1'b1;
                else if (!m_sda_p && sda_l) begin
                    // an SDA dip while SCL stays high is not a real START
                    if (m_pend) m_pend = 1'b0;
                    else        mlog.push_back(EV_STOP);
                end
            end
            if (!m_scl_p && scl_l) begin
                if (m_bitn < 8) begin
                    m_sh = {m_sh[6:0], sda_l};
                    m_bitn++;
                    if (m_bitn == 8) begin
                        mlog.push_back(int'(m_sh));
                        if (m_frame == 0) m_rd = sda_l;
                    end
                end else begin
                    mlog.push_back(EV_ACK + int'(sda_l));
                    if (m_rd && m_frame > 0 && sda_l) m_nacked = 1'b1;
                    m_bitn = 0;
                    m_frame++;
                end
            end
            if (m_scl_p && !scl_l) begin
                if (m_pend) begin
                    mlog.push_back(EV_START);
                    m_pend   = 1'b0;
                    m_bitn   = 0;
                    m_frame  = 0;
                    m_rd     = 1'b0;
                    m_nacked = 1'b0;
                    slv_pull = 1'b0;
                end else if (m_bitn == 8) begin
                    slv_pull = (m_frame == 0 || !m_rd) ? ack_en : 1'b0;
                end else if (m_rd && m_frame > 0 && !m_nacked) begin
                    slv_pull = ~rd_byte[7 - m_bitn];
                end else begin
                    slv_pull = 1'b0;
                end
            end
            m_scl_p = scl_l;
            m_sda_p = sda_l;
        end
    end

    task automatic wait_busy(input string tag, input logic val);
        int n = 0;
        while (busy !== val && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'(val));
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, mlog.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), (i < mlog.size()) ? mlog[i] : -1, exp_q[i]);
    endtask

    task automatic start_cmd(input logic [6:0] a, input logic r, input logic [7:0] d);
        addr    = a;
        rw      = r;
        data_wr = d;
        ena     = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        logic hit;
        reset = 1'b0; ena = 1'b0; addr = '0; rw = 1'b0; data_wr = '0;
        repeat (5) @(negedge clk);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_sda_oe", 32'(sda_oe),    32'd0);
        check("rst_scl_oe", 32'(scl_oe),    32'd0);
        check("rst_rd",     32'(data_rd),   32'd0);
        check("rst_ackerr", 32'(ack_error), 32'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        // Single write 0x50 / 0xA5
        mlog.delete(); ack_en = 1'b1;
        start_cmd(7'h50, 1'b0, 8'hA5);
        wait_busy("wr_acc", 1'b1);
        ena = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("wr_busy_clks", n, 320);
        exp_q = '{EV_START, 'hA0, EV_ACK, 'hA5, EV_ACK, EV_STOP};
        check_log("wr");
        check("wr_ackerr", 32'(ack_error), 32'd0);
        check("wr_scl_rel", 32'(scl_oe), 32'd0);
        repeat (40) @(negedge clk);

        // Address NACK
        mlog.delete(); ack_en = 1'b0;
        start_cmd(7'h51, 1'b0, 8'h77);
        wait_busy("nack_acc", 1'b1);
        ena = 1'b0;
        wait_busy("nack_done", 1'b0);
        exp_q = '{EV_START, 'hA2, EV_ACK + 1, 'h77, EV_ACK + 1, EV_STOP};
        check_log("nack");
        check("nack_ackerr", 32'(ack_error), 32'd1);
        repeat (40) @(negedge clk);

        // Single read 0x48, slave returns 0x3C, master NACKs
        mlog.delete(); ack_en = 1'b1; rd_byte = 8'h3C;
        start_cmd(7'h48, 1'b1, 8'h00);
        wait_busy("rd_acc", 1'b1);
        ena = 1'b0;
        wait_busy("rd_done", 1'b0);
        exp_q = '{EV_START, 'h91, EV_ACK, 'h3C, EV_ACK + 1, EV_STOP};
        check_log("rd");
        check("rd_data", 32'(data_rd), 32'h3C);
        check("rd_ackerr_clr", 32'(ack_error), 32'd0);
        repeat (40) @(negedge clk);

        // Two-byte write: next byte presented once the first command is accepted
        mlog.delete();
        start_cmd(7'h50, 1'b0, 8'h11);
        wait_busy("wr2_acc", 1'b1);
        data_wr = 8'h22;
        wait_busy("wr2_next", 1'b0);
        ena = 1'b0;
        wait_busy("wr2_b2", 1'b1);
        wait_busy("wr2_done", 1'b0);
        exp_q = '{EV_START, 'hA0, EV_ACK, 'h11, EV_ACK, 'h22, EV_ACK, EV_STOP};
        check_log("wr2");
        repeat (40) @(negedge clk);

        // Repeated START: write 0x0F then read from the same slave
        mlog.delete(); rd_byte = 8'h5A;
        start_cmd(7'h50, 1'b0, 8'h0F);
        wait_busy("rs_acc", 1'b1);
        rw = 1'b1;
        wait_busy("rs_next", 1'b0);
        wait_busy("rs_restart", 1'b1);
        ena = 1'b0;
        wait_busy("rs_done", 1'b0);
        exp_q = '{EV_START, 'hA0, EV_ACK, 'h0F, EV_ACK,
                  EV_START, 'hA1, EV_ACK, 'h5A, EV_ACK + 1, EV_STOP};
        check_log("rs");
        check("rs_data", 32'(data_rd), 32'h5A);
        repeat (40) @(negedge clk);

        // Reset during WR bit 4
        mlog.delete();
        start_cmd(7'h50, 1'b0, 8'h00);
        wait_busy("mr_acc", 1'b1);
        ena = 1'b0;
        n = 0; hit = 1'b0;
        while (!hit && n < 4000) begin
            @(negedge clk);
            n++;
            hit = (m_frame == 1 && m_bitn == 3 && scl_oe === 1'b1 && data_clk);
        end
        check("mr_reach", 32'(hit), 32'd1);
        check("mr_pre_sda", 32'(sda_oe), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mr_sda_oe", 32'(sda_oe), 32'd0);
        check("mr_scl_oe", 32'(scl_oe), 32'd0);
        check("mr_busy",   32'(busy),   32'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);

        // Recovery write after the mid-transfer reset
        mlog.delete();
        start_cmd(7'h2A, 1'b0, 8'h3C);
        wait_busy("rec_acc", 1'b1);
        ena = 1'b0;
        wait_busy("rec_done", 1'b0);
        exp_q = '{EV_START, 'h54, EV_ACK, 'h3C, EV_ACK, EV_STOP};
        check_log("rec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Byte-level I2C master state machine that turns a parallel command (7-bit address, R/W, write byte) into START/address/data/ACK/STOP sequences on open-drain SDA/SCL. Sits directly downstream of the I2C clock divider and consumes its `scl_clk`, `data_clk` and `data_clk_prev` phase outputs. Supports multi-byte writes and reads, and repeated START on address or direction change. Sits between user logic (sensor FSMs) and the BASYS3 Pmod pins.

## Interface
- No parameters. Bus rate is set entirely by the divider.
- `clk` in 1: system clock, same clock as the divider.
- `reset` in 1: synchronous, active-low; sampled on posedge `clk`.
- `scl_clk` in 1: divider SCL phase.
- `data_clk` in 1: divider data phase.
- `data_clk_prev` in 1: `data_clk` delayed one `clk`.
- `ena` in 1: transaction request/continue, level-sensitive.
- `addr` in 7: slave address.
- `rw` in 1: 0 = write, 1 = read.
- `data_wr` in 8: byte to write.
- `sda_in` in 1: synchronised SDA pin level.
- `busy` out 1: command accepted / transfer in progress.
- `data_rd` out 8: last byte read.
- `ack_error` out 1: slave NACK seen since last START.
- `sda_oe` out 1: 1 = pull SDA low; 0 = release.
- `scl_oe` out 1: 1 = pull SCL low; 0 = release.

## Operation
- Events:
  - `rise` = `data_clk & ~data_clk_prev`. SCL is low (phase 1). All state transitions and SDA bit changes occur here.
  - `fall` = `~data_clk & data_clk_prev`. SCL is high (phase 3). All SDA sampling and `scl_ena` updates occur here.
- Divider phases (`scl_clk`, `data_clk`): 0 = (0,0), 1 = (0,1), 2 = (1,1), 3 = (1,0).
- Internal registers: `state`, `scl_ena`, `sda_int`, `bit_cnt[2:0]`, `addr_rw[7:0]`, `data_tx[7:0]`, `data_rx[7:0]`.
- `scl_oe = scl_ena & ~scl_clk`.
- `sda_oe` by state:
  - START: high only in phase 3.
  - STOP: high in phases 0–2.
  - All other states: `~sda_int`.
- States and transitions on `rise`:
  - READY: `busy`=0, `sda_int`=1. If `ena`, latch `{addr,rw}`→`addr_rw` and `data_wr`→`data_tx`, set `busy`=1, go to START. Otherwise stay.
  - START: `busy`=1, clear `ack_error`, `sda_int`=`addr_rw[7]`, `bit_cnt`=7, go to COMMAND.
  - COMMAND: if `bit_cnt`=0, `sda_int`=1 and go to SLV_ACK1. Otherwise decrement `bit_cnt` and drive `addr_rw[bit_cnt-1]`.
  - SLV_ACK1: `bit_cnt`=7. If `addr_rw[0]`=0, drive `data_tx[7]` and go to WR. Else `sda_int`=1 and go to RD.
  - WR: `busy`=1. Shift out MSB-first. After bit 0, `sda_int`=1 and go to SLV_ACK2.
  - RD: `busy`=1. After bit 0, `data_rd`←`data_rx` and go to MSTR_ACK. `sda_int`=0 (ACK) if `ena` and `{addr,rw}`==`addr_rw`, else 1 (NACK).
  - SLV_ACK2 / MSTR_ACK: if `ena`, `busy`=0 and latch the new command.
    - Same `addr_rw`: continue in WR (driving `data_wr[7]`) or RD.
    - Different `addr_rw`: go to START (repeated START).
    - If `ena`=0: go to STOP.
  - STOP: `busy`=0, go to READY.
- Actions on `fall`:
  - START: `scl_ena`=1.
  - STOP: `scl_ena`=0.
  - SLV_ACK1 / SLV_ACK2: `ack_error` |= `sda_in`.
  - RD: `data_rx[bit_cnt]`←`sda_in`.
- NACK does not abort the transfer. User logic reads `ack_error` and drops `ena`.

## Timing
- Reset values:
  - state READY, `busy`=0, `scl_ena`=0, `sda_int`=1, `bit_cnt`=7.
  - `data_rd`=0, `ack_error`=0, `sda_oe`=0, `scl_oe`=0.
- Reset mid-transfer releases both lines on the next `clk` edge. No STOP is generated.
- `ena` is sampled only on `rise`. Latency to START is at most one SCL period.
- `busy` rises on the `rise` that accepts a command.
- Continuation handshake: `busy` falls on the `rise` entering the next byte. This is the window for user logic to present the next command; it must be valid before the following ACK-state `rise`.
- One byte + ACK = 9 SCL periods. Single-byte write, START to READY = 20 SCL periods.
- `data_rd` is valid from the `rise` entering MSTR_ACK until the next read completes.
- START edge: SDA falls in phase 3 while SCL is high (released by `scl_ena`=0, or running high for repeated START).
- STOP edge: SDA rises in phase 3 with SCL high, after which SCL stays released.
- `rise` and `fall` are never coincident. If the divider is held in reset, no events occur and state freezes.

## Test plan
- Write: `addr`=0x50, `rw`=0, `data_wr`=0xA5, pulse `ena`, slave ACKs both → SDA bits `1010000 0`, ACK, `10100101`, ACK, then STOP; `ack_error`=0; `busy` low after STOP.
- Address NACK: `addr`=0x51, `sda_in` held 1 → `ack_error`=1 sampled in SLV_ACK1; transfer completes with STOP; `ack_error` clears at the next START.
- Read: `addr`=0x48, `rw`=1, slave returns 0x3C, `ena` dropped during byte → `data_rd`=0x3C; master NACKs (SDA released in ACK bit); then STOP.
- Two-byte write: `data_wr` 0x11 then 0x22, `ena` held, new data presented after `busy` falls → both bytes sent with no intermediate START; single STOP.
- Repeated START: write 0x50/0x0F, then switch `rw`=1 while `ena` held → SDA falls with SCL high (no STOP between); address byte 0xA1 sent.
- Reset mid-byte: `reset`=0 during WR bit 4 → next `clk`: `sda_oe`=0, `scl_oe`=0, `busy`=0, state READY.
